// File: rtl/conv3x3_same_256x256.sv
// 3x3 "same" convolution over a COLS x ROWS signed 9-bit raster stream, with bias, rounding and saturation.
// Optional macro CONV3X3_RELU_EN clamps negative results to zero in the last stage.
module conv3x3_same_256x256 #(
  parameter int COLS = 256,
  parameter int ROWS = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de,
  input  logic signed [8:0]  data_in,
  input  logic signed [10:0] k1,
  input  logic signed [10:0] k2,
  input  logic signed [10:0] k3,
  input  logic signed [10:0] k4,
  input  logic signed [10:0] k5,
  input  logic signed [10:0] k6,
  input  logic signed [10:0] k7,
  input  logic signed [10:0] k8,
  input  logic signed [10:0] k9,
  input  logic signed [19:0] bias,
  output logic               de_o,
  output logic signed [8:0]  data,
  output logic               frame_done,
  output logic               err
);

  localparam int NPIX = ROWS * COLS;
  localparam int TW   = $clog2(NPIX + COLS + 1);
  localparam int CW   = $clog2(COLS);
  localparam int RW   = $clog2(ROWS);
  localparam logic [TW-1:0] T_RUN_END = TW'(NPIX - 1);
  localparam logic [TW-1:0] T_LAST    = TW'(NPIX + COLS);
  localparam logic [TW-1:0] T_FIRST   = TW'(COLS + 1);
  localparam logic [CW-1:0] COL_MAX   = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     pcol_q, pcol_d;
  logic [RW-1:0]     prow_q, prow_d;
  logic              err_q, err_d;

  logic signed [8:0] win_q [3][3];
  logic signed [8:0] win_d [3][3];
  logic signed [8:0] lb1 [COLS];
  logic signed [8:0] lb2 [COLS];
  logic signed [8:0] lb1_rd, lb2_rd;

  logic [8:0]         mask_q, mask_d;
  logic               v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic               last0_q, last0_d, last1_q, last1_d, last2_q, last2_d, last3_q, last3_d;
  logic signed [19:0] prod_q [9];
  logic signed [19:0] prod_d [9];
  logic signed [21:0] rsum_q [3];
  logic signed [21:0] rsum_d [3];
  logic signed [23:0] acc_q, acc_d;
  logic signed [23:0] shifted;
  logic signed [8:0]  sat;
  logic               de_o_q, de_o_d;
  logic signed [8:0]  data_q, data_d;
  logic               frame_done_q, frame_done_d;

  logic               tick, emit;
  logic signed [8:0]  pix;
  logic signed [10:0] kw [9];

  assign lb1_rd = lb1[ptr_q];
  assign lb2_rd = lb2[ptr_q];

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    ptr_d   = ptr_q;
    pcol_d  = pcol_q;
    prow_d  = prow_q;
    err_d   = err_q;
    tick    = 1'b0;
    pix     = '0;
    mask_d  = mask_q;
    win_d   = win_q;
    kw[0] = k1; kw[1] = k2; kw[2] = k3;
    kw[3] = k4; kw[4] = k5; kw[5] = k6;
    kw[6] = k7; kw[7] = k8; kw[8] = k9;

    case (state_q)
      IDLE: begin
        if (de) begin
          tick    = 1'b1;
          pix     = data_in;
          state_d = RUN;
        end
      end
      RUN: begin
        if (de) begin
          tick = 1'b1;
          pix  = data_in;
          if (tcnt_q == T_RUN_END) state_d = FLUSH;
        end
      end
      FLUSH: begin
        tick = 1'b1;
        if (de) err_d = 1'b1;
        if (tcnt_q == T_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    emit = tick && (tcnt_q >= T_FIRST);

    if (tick) begin
      tcnt_d = (tcnt_q == T_LAST) ? '0 : tcnt_q + 1'b1;
      ptr_d  = (ptr_q == COL_MAX) ? '0 : ptr_q + 1'b1;
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb2_rd;
      win_d[1][2] = lb1_rd;
      win_d[2][2] = pix;
    end

    // Border taps are masked on the centre's coordinates, which also hides wrap-around pixels.
    if (emit) begin
      for (int i = 0; i < 9; i++) begin
        mask_d[i] = !((i < 3) && (prow_q == '0)) &&
                    !((i >= 6) && (prow_q == ROW_MAX)) &&
                    !((i % 3 == 0) && (pcol_q == '0)) &&
                    !((i % 3 == 2) && (pcol_q == COL_MAX));
      end
      if (pcol_q == COL_MAX) begin
        pcol_d = '0;
        prow_d = (prow_q == ROW_MAX) ? '0 : prow_q + 1'b1;
      end else begin
        pcol_d = pcol_q + 1'b1;
      end
    end

    v0_d    = emit;
    last0_d = emit && (tcnt_q == T_LAST);
    v1_d    = v0_q;
    last1_d = last0_q;
    v2_d    = v1_q;
    last2_d = last1_q;
    v3_d    = v2_q;
    last3_d = last2_q;

    for (int i = 0; i < 9; i++)
      prod_d[i] = mask_q[i] ? win_q[i / 3][i % 3] * kw[i] : 20'sd0;
    for (int r = 0; r < 3; r++)
      rsum_d[r] = prod_q[3*r] + prod_q[3*r+1] + prod_q[3*r+2];
    acc_d = rsum_q[0] + rsum_q[1] + rsum_q[2] + bias + 24'sd512;

    shifted = acc_q >>> 10;
`ifdef CONV3X3_RELU_EN
    if (shifted > 24'sd255)     sat = 9'sd255;
    else if (shifted < 24'sd0)  sat = 9'sd0;
    else                        sat = shifted[8:0];
`else
    if (shifted > 24'sd255)       sat = 9'sd255;
    else if (shifted < -24'sd255) sat = -9'sd255;
    else                          sat = shifted[8:0];
`endif

    de_o_d       = v3_q;
    data_d       = v3_q ? sat : data_q;
    frame_done_d = v3_q && last3_q;
  end

  // Line buffers carry no reset; stale contents only ever reach masked taps.
  always_ff @(posedge clk) begin
    if (tick) begin
      lb1[ptr_q] <= pix;
      lb2[ptr_q] <= lb1_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tcnt_q       <= '0;
      ptr_q        <= '0;
      pcol_q       <= '0;
      prow_q       <= '0;
      err_q        <= 1'b0;
      mask_q       <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
      v0_q <= 1'b0; v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
      last0_q <= 1'b0; last1_q <= 1'b0; last2_q <= 1'b0; last3_q <= 1'b0;
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      for (int r = 0; r < 3; r++) rsum_q[r] <= '0;
      acc_q        <= '0;
      de_o_q       <= 1'b0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      ptr_q        <= ptr_d;
      pcol_q       <= pcol_d;
      prow_q       <= prow_d;
      err_q        <= err_d;
      mask_q       <= mask_d;
      win_q        <= win_d;
      v0_q <= v0_d; v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d;
      last0_q <= last0_d; last1_q <= last1_d; last2_q <= last2_d; last3_q <= last3_d;
      prod_q       <= prod_d;
      rsum_q       <= rsum_d;
      acc_q        <= acc_d;
      de_o_q       <= de_o_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign de_o       = de_o_q;
  assign data       = data_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule
